// File: rtl/rmt_action_pkg.sv
// Shared definitions for RMT action-stage lanes: opcodes, action word fields
// and the issue FSM state type.
package rmt_action_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_GEQ  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_SET  = 4'b1110;

  localparam int unsigned ACT_OP_LSB   = 21;
  localparam int unsigned ACT_OP_W     = 4;
  localparam int unsigned ACT_SRC1_LSB = 16;
  localparam int unsigned ACT_SRC2_LSB = 11;
  localparam int unsigned ACT_IMM_LSB  = 0;
  localparam int unsigned ACT_IMM_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_1_opsel.sv
// Combinational operand selector: decodes an action word and picks the two
// ALU operands from PHV containers or the immediate field.
module alu_1_opsel
  import rmt_action_pkg::*;
#(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int NUM_CONT   = 8,
  parameter int DST_IDX    = 0
) (
  input  logic [ACTION_LEN-1:0]          action,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
  output logic [DATA_WIDTH-1:0]          operand_1,
  output logic [DATA_WIDTH-1:0]          operand_2
);

  localparam int unsigned IW = (NUM_CONT > 1) ? $clog2(NUM_CONT) : 1;
  localparam logic [IW-1:0] DST = IW'(DST_IDX);

  logic [DATA_WIDTH-1:0] cont [NUM_CONT];
  logic [3:0]            op;
  logic [IW-1:0]         idx_1;
  logic [IW-1:0]         idx_2;
  logic [DATA_WIDTH-1:0] imm;
  logic                  unused_action;

  for (genvar i = 0; i < NUM_CONT; i++) begin : g_cont
    assign cont[i] = phv[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the low index bits are used, so out-of-range indices wrap.
  assign op    = action[ACT_OP_LSB +: ACT_OP_W];
  assign idx_1 = action[ACT_SRC1_LSB +: IW];
  assign idx_2 = action[ACT_SRC2_LSB +: IW];
  assign imm   = {{(DATA_WIDTH-ACT_IMM_W){1'b0}}, action[ACT_IMM_LSB +: ACT_IMM_W]};
  assign unused_action = &{1'b0, action};

  always_comb begin
    operand_1 = cont[DST];
    operand_2 = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_GEQ: begin
        operand_1 = cont[idx_1];
        operand_2 = cont[idx_2];
      end
      OP_ADDI, OP_SUBI: begin
        operand_1 = cont[idx_1];
        operand_2 = imm;
      end
      OP_SET: begin
        operand_1 = cont[DST];
        operand_2 = imm;
      end
      default: begin
        operand_1 = cont[DST];
        operand_2 = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_1_issue.sv
// Per-lane operand issuer and write-back collector: issues one operation per
// PHV to the lane ALU and writes its result into container DST_IDX.
module alu_1_issue
  import rmt_action_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int NUM_CONT   = 8,
  parameter int DST_IDX    = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
  input  logic [ACTION_LEN-1:0]          action_in,
  input  logic                           phv_in_valid,
  output logic                           phv_in_ready,
  output logic [ACTION_LEN-1:0]          alu_action,
  output logic                           alu_action_valid,
  output logic [DATA_WIDTH-1:0]          alu_operand_1,
  output logic [DATA_WIDTH-1:0]          alu_operand_2,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           alu_result_valid,
  output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  output logic                           timeout_err
);

  localparam int unsigned unused_stage = STAGE_ID;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t                         state;
  state_t                         state_nxt;
  logic [NUM_CONT*DATA_WIDTH-1:0] phv_buf;
  logic [ACTION_LEN-1:0]          act_q;
  logic [DATA_WIDTH-1:0]          op_1_q;
  logic [DATA_WIDTH-1:0]          op_2_q;
  logic [DATA_WIDTH-1:0]          op_1_d;
  logic [DATA_WIDTH-1:0]          op_2_d;
  logic [CW-1:0]                  wait_cnt;
  logic                           err_q;

  alu_1_opsel #(
    .ACTION_LEN (ACTION_LEN),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CONT   (NUM_CONT),
    .DST_IDX    (DST_IDX)
  ) u_opsel (
    .action    (action_in),
    .phv       (phv_in),
    .operand_1 (op_1_d),
    .operand_2 (op_2_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Ready is qualified with rst_n so it reads low while reset is held.
  always_comb begin
    state_nxt        = state;
    phv_in_ready     = 1'b0;
    alu_action_valid = 1'b0;
    phv_out_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        phv_in_ready = rst_n;
        if (phv_in_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_action_valid = 1'b1;
        state_nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_result_valid || wait_cnt == TMO) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        phv_out_valid = 1'b1;
        if (phv_out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A result arriving on the TIMEOUT cycle takes priority over the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_buf  <= '0;
      act_q    <= '0;
      op_1_q   <= '0;
      op_2_q   <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (phv_in_valid) begin
            phv_buf <= phv_in;
            act_q   <= action_in;
            op_1_q  <= op_1_d;
            op_2_q  <= op_2_d;
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT: begin
          if (alu_result_valid)
            phv_buf[DST_IDX*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
          else if (wait_cnt == TMO)
            err_q <= 1'b1;
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_action    = act_q;
  assign alu_operand_1 = op_1_q;
  assign alu_operand_2 = op_2_q;
  assign phv_out       = phv_buf;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_alu_1_issue.sv
// Directed bench for alu_1_issue with a 2-cycle-latency ALU model on the lane.
module tb_alu_1_issue;

  localparam int DW = 48;
  localparam int NC = 8;
  localparam int AL = 25;
  localparam int PW = NC * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] phv_in;
  logic [AL-1:0] action_in;
  logic          phv_in_valid;
  logic          phv_in_ready;
  logic [AL-1:0] alu_action;
  logic          alu_action_valid;
  logic [DW-1:0] alu_operand_1;
  logic [DW-1:0] alu_operand_2;
  logic [DW-1:0] alu_result;
  logic          alu_result_valid;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready;
  logic          timeout_err;

  always #5 clk = ~clk;

  alu_1_issue #(
    .STAGE_ID   (0),
    .ACTION_LEN (AL),
    .DATA_WIDTH (DW),
    .NUM_CONT   (NC),
    .DST_IDX    (0),
    .TIMEOUT    (15)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .phv_in           (phv_in),
    .action_in        (action_in),
    .phv_in_valid     (phv_in_valid),
    .phv_in_ready     (phv_in_ready),
    .alu_action       (alu_action),
    .alu_action_valid (alu_action_valid),
    .alu_operand_1    (alu_operand_1),
    .alu_operand_2    (alu_operand_2),
    .alu_result       (alu_result),
    .alu_result_valid (alu_result_valid),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .phv_out_ready    (phv_out_ready),
    .timeout_err      (timeout_err)
  );

  // Lane ALU: result appears two cycles after the action_valid cycle.
  logic          alu_en  = 1'b1;
  logic          mv1     = 1'b0;
  logic          mv2     = 1'b0;
  logic [DW-1:0] mr1     = '0;
  logic [DW-1:0] mr2     = '0;
  logic          stale_v = 1'b0;
  logic [DW-1:0] stale_val = '0;
  logic [3:0]    m_op;

  assign m_op = alu_action[24:21];
  always @(posedge clk) begin
    mv1 <= alu_action_valid & alu_en;
    mr1 <= (m_op == 4'b0010 || m_op == 4'b1010) ? alu_operand_1 - alu_operand_2
                                                : alu_operand_1 + alu_operand_2;
    mv2 <= mv1;
    mr2 <= mr1;
  end
  assign alu_result_valid = mv2 | stale_v;
  assign alu_result       = stale_v ? stale_val : mr2;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] put(input logic [PW-1:0] pv, input int i, input logic [DW-1:0] v);
    logic [PW-1:0] r;
    r = pv;
    r[i*DW +: DW] = v;
    return r;
  endfunction

  // Drive a packet on a negedge; return on the negedge of the ISSUE cycle.
  task automatic send(input logic [PW-1:0] pv, input logic [AL-1:0] act);
    int k;
    @(negedge clk);
    phv_in = pv;
    action_in = act;
    phv_in_valid = 1'b1;
    k = 0;
    while (!phv_in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", phv_in_ready, 1'b1);
    @(negedge clk);
    phv_in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!phv_out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    phv_out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", phv_out_valid, 1'b0);
    chk("hs_in_ready", phv_in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [PW-1:0] base, pv, exp_phv;
  logic [AL-1:0] act;
  int cyc;

  initial begin
    rst_n = 1'b0;
    phv_in = '0;
    action_in = '0;
    phv_in_valid = 1'b0;
    phv_out_ready = 1'b1;
    base = '0;
    for (int i = 0; i < NC; i++) base = put(base, i, 48'h1000 + 48'h11 * i);

    #2;
    chk("rst_in_ready", phv_in_ready, 1'b0);
    chk("rst_act_valid", alu_action_valid, 1'b0);
    chk("rst_action", alu_action, '0);
    chk("rst_op1", alu_operand_1, '0);
    chk("rst_op2", alu_operand_2, '0);
    chk("rst_phv_out", phv_out, '0);
    chk("rst_out_valid", phv_out_valid, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", phv_in_ready, 1'b1);

    // ADD cont2 + cont5 -> cont0
    pv = put(put(base, 2, 48'd10), 5, 48'd7);
    act = {4'b0001, 5'd2, 5'd5, 11'd0};
    send(pv, act);
    chk("add_act_valid", alu_action_valid, 1'b1);
    chk("add_op1", alu_operand_1, 48'd10);
    chk("add_op2", alu_operand_2, 48'd7);
    chk("add_action", alu_action, act);
    chk("add_busy", phv_in_ready, 1'b0);
    @(negedge clk);
    chk("add_pulse_once", alu_action_valid, 1'b0);
    wait_out(cyc);
    chk("add_latency", 2 + cyc, 4);
    chk("add_phv_out", phv_out, put(pv, 0, 48'd17));
    handshake();

    // ADDI with wrap, under backpressure, followed by an index-wrap packet
    phv_out_ready = 1'b0;
    pv = put(base, 1, 48'hFFFF_FFFF_FFFF);
    act = {4'b1001, 5'd1, 16'h0001};
    send(pv, act);
    chk("addi_op1", alu_operand_1, 48'hFFFF_FFFF_FFFF);
    chk("addi_op2", alu_operand_2, 48'h1);
    wait_out(cyc);
    chk("addi_latency", 1 + cyc, 4);
    exp_phv = put(pv, 0, 48'h0);
    chk("addi_phv_out", phv_out, exp_phv);
    chk("addi_err", timeout_err, 1'b0);
    phv_in = base;
    action_in = {4'b0001, 5'd10, 5'd13, 11'd0};
    phv_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", phv_out_valid, 1'b1);
      chk("bp_phv_stable", phv_out, exp_phv);
      chk("bp_in_ready", phv_in_ready, 1'b0);
      chk("bp_no_issue", alu_action_valid, 1'b0);
    end
    phv_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", phv_in_ready, 1'b1);
    chk("bp_release_valid", phv_out_valid, 1'b0);
    @(negedge clk);
    phv_in_valid = 1'b0;
    chk("wrap_act_valid", alu_action_valid, 1'b1);
    chk("wrap_op1", alu_operand_1, 48'h1022);
    chk("wrap_op2", alu_operand_2, 48'h1055);
    wait_out(cyc);
    chk("wrap_phv_out", phv_out, put(base, 0, 48'h2077));
    handshake();

    // Result arriving exactly on the TIMEOUT cycle is accepted
    alu_en = 1'b0;
    send(base, {4'b0010, 5'd3, 5'd4, 11'd0});
    repeat (15) @(negedge clk);
    chk("edge_not_yet", phv_out_valid, 1'b0);
    @(negedge clk);
    stale_v = 1'b1;
    stale_val = 48'hABCD;
    @(negedge clk);
    stale_v = 1'b0;
    chk("edge_out_valid", phv_out_valid, 1'b1);
    chk("edge_phv_out", phv_out, put(base, 0, 48'hABCD));
    chk("edge_no_err", timeout_err, 1'b0);
    handshake();

    // ALU never answers
    pv = put(base, 3, 48'h5555);
    send(pv, {4'b0001, 5'd3, 5'd3, 11'd0});
    wait_out(cyc);
    chk("tmo_wait_cycles", cyc, 17);
    chk("tmo_phv_unchanged", phv_out, pv);
    chk("tmo_err", timeout_err, 1'b1);
    handshake();

    // Default opcode; error stays sticky
    alu_en = 1'b1;
    pv = put(base, 0, 48'h77);
    send(pv, {4'b0000, 21'h1ABCDE});
    chk("dflt_op1", alu_operand_1, 48'h77);
    chk("dflt_op2", alu_operand_2, 48'h0);
    wait_out(cyc);
    chk("dflt_phv_out", phv_out, pv);
    chk("dflt_err_sticky", timeout_err, 1'b1);
    handshake();

    // Reset while waiting for the ALU
    send(base, {4'b0001, 5'd2, 5'd5, 11'd0});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", phv_in_ready, 1'b0);
    chk("mrst_act_valid", alu_action_valid, 1'b0);
    chk("mrst_action", alu_action, '0);
    chk("mrst_op1", alu_operand_1, '0);
    chk("mrst_op2", alu_operand_2, '0);
    chk("mrst_phv_out", phv_out, '0);
    chk("mrst_out_valid", phv_out_valid, 1'b0);
    chk("mrst_err", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stale_v = 1'b1;
    stale_val = 48'hDEAD;
    @(negedge clk);
    stale_v = 1'b0;
    chk("stale_phv_out", phv_out, '0);
    chk("stale_out_valid", phv_out_valid, 1'b0);
    chk("stale_in_ready", phv_in_ready, 1'b1);
    pv = put(base, 4, 48'd100);
    send(pv, {4'b1001, 5'd4, 16'd23});
    chk("after_rst_op1", alu_operand_1, 48'd100);
    chk("after_rst_op2", alu_operand_2, 48'd23);
    wait_out(cyc);
    chk("after_rst_latency", 1 + cyc, 4);
    chk("after_rst_phv_out", phv_out, put(pv, 0, 48'd123));
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_1_issue.md
Name: alu_1_issue

Overview:
- Per-lane operand issuer and write-back collector for one ALU lane of an RMT action stage; it drives the lane ALU's input interface and consumes its result.
- Accepts a PHV (NUM_CONT containers, each DATA_WIDTH bits) together with a 25-bit action word.
- Decodes the action, fetches the two operands from PHV containers or the immediate, and issues them to the ALU with a one-cycle action_valid pulse.
- Waits for container_out_valid, then writes the result into container DST_IDX and emits the updated PHV.

Parameters:
- STAGE_ID, 0, stage index; informational only.
- ACTION_LEN, 25, action word width.
- DATA_WIDTH, 48, container and ALU width.
- NUM_CONT, 8, containers per PHV (power of 2, at most 32).
- DST_IDX, 0, container written back by this lane.
- TIMEOUT, 15, maximum wait cycles for the ALU result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- phv_in  in  NUM_CONT*DATA_WIDTH  input PHV; container i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- action_in  in  ACTION_LEN  action for this lane.
- phv_in_valid  in  1  PHV and action valid.
- phv_in_ready  out  1  block can accept.
- alu_action  out  ACTION_LEN  to ALU action_in.
- alu_action_valid  out  1  to ALU action_valid; one-cycle pulse.
- alu_operand_1  out  DATA_WIDTH  to ALU operand_1_in.
- alu_operand_2  out  DATA_WIDTH  to ALU operand_2_in.
- alu_result  in  DATA_WIDTH  from ALU container_out.
- alu_result_valid  in  1  from ALU container_out_valid.
- phv_out  out  NUM_CONT*DATA_WIDTH  updated PHV.
- phv_out_valid  out  1  output valid.
- phv_out_ready  in  1  downstream accept.
- timeout_err  out  1  sticky; set on ALU timeout.

Behaviour:
- Action decode, with op = action[24:21]:
  - 0001/0010: op1 = cont[action[20:16]], op2 = cont[action[15:11]].
  - 1001/1010: op1 = cont[action[20:16]], op2 = zero-extended action[15:0].
  - 1110: op1 = cont[DST_IDX], op2 = zero-extended action[15:0].
  - 0100/0101/0110 decode as 0001.
  - Every other op: op1 = cont[DST_IDX], op2 = 0.
- Container indices use the low log2(NUM_CONT) bits; upper index bits are ignored (wrap).
- States:
  - IDLE:
    - phv_in_ready = 1.
    - On phv_in_valid, latch phv_in into phv_buf, latch the decoded action and operands into registers, and go to ISSUE.
  - ISSUE:
    - alu_action_valid = 1 for exactly this cycle, with registered alu_action/operands stable; clear wait_cnt.
    - Go to WAIT.
  - WAIT:
    - wait_cnt increments each cycle.
    - On alu_result_valid, phv_buf[DST_IDX] <= alu_result and go to OUT.
    - If wait_cnt == TIMEOUT without alu_result_valid, phv_buf is left unchanged, timeout_err <= 1, and go to OUT.
  - OUT:
    - phv_out_valid = 1 and phv_out = phv_buf, held stable until phv_out_ready.
    - On phv_out_ready, go to IDLE.
- phv_in_ready is 0 in every state other than IDLE; there is no overlap between packets.
- Latency: against an ALU that returns its result 2 cycles after action_valid, input acceptance to phv_out_valid is 4 cycles (accept edge, ISSUE, 2 WAIT cycles, then OUT).
- alu_result_valid asserted outside WAIT is ignored.
- An alu_result_valid in the same cycle that wait_cnt reaches TIMEOUT counts as a result: the write-back happens and there is no error.
- Reset mid-operation returns the block to IDLE and discards the in-flight PHV.
- Reset values:
  - phv_in_ready = 0 during reset; 1 after.
  - alu_action_valid = 0, alu_action = 0, alu_operand_1 = 0, alu_operand_2 = 0.
  - phv_out = 0, phv_out_valid = 0, timeout_err = 0, state = IDLE.
- timeout_err clears only on reset.

Decomposition:
- Shared package rmt_action_pkg holds:
  - Opcode localparams: OP_ADD=4'b0001, OP_SUB=4'b0010, OP_AND=4'b0100, OP_OR=4'b0101, OP_GEQ=4'b0110, OP_ADDI=4'b1001, OP_SUBI=4'b1010, OP_SET=4'b1110.
  - Action field bit positions.
  - State encodings.
- One combinational sub-module, alu_1_opsel: action plus PHV in, alu_operand_1/alu_operand_2 out. It is reusable by other lanes.

Test Plan:
- ADD: cont2=10, cont5=7, action={0001,5'd2,5'd5,11'd0}, DST_IDX=0; ALU model with 2-cycle latency -> one alu_action_valid pulse with operands 10 and 7; phv_out cont0=17, other containers unchanged; phv_out_valid 4 cycles after accept.
- ADDI: cont1=48'hFFFF_FFFF_FFFF, imm=16'h0001 -> operand_2=48'h1; cont0 written with the ALU result 0 (wrap); timeout_err=0.
- Backpressure: phv_out_ready held low 5 cycles -> phv_out_valid stays 1, phv_out stable, phv_in_ready=0; second PHV accepted only after the handshake.
- Timeout: ALU never responds -> after TIMEOUT+1 WAIT cycles phv_out equals phv_in unchanged; timeout_err=1 and stays 1 across the next packet.
- Index wrap with NUM_CONT=8: op1 index 5'd10 -> cont2 is selected. Default op 4'b0000 -> operand_1=cont[DST_IDX], operand_2=0.
- Reset asserted in WAIT -> outputs reach their reset values asynchronously; after release, a new PHV processes normally and a stale alu_result_valid is ignored.
